// File: rtl/frame_ring_buffer.sv
// Ring buffer that re-emits overlapping frames (FRAME_LEN long, HOP apart).
// Define FRAME_RING_OVF_EN to add the sticky ovf flag and its ovf_clr input.
module frame_ring_buffer #(
  parameter int BITS      = 12,
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128,
  parameter int DEPTH     = 512,
  localparam int AW       = $clog2(DEPTH),
  localparam int IW       = $clog2(FRAME_LEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  input  logic            out_ready,
  output logic [15:0]     frame_cnt
`ifdef FRAME_RING_OVF_EN
  ,
  output logic            ovf,
  input  logic            ovf_clr
`endif
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0]   FL_W    = (AW+1)'(FRAME_LEN);
  localparam logic [AW:0]   HOP_W   = (AW+1)'(HOP);
  localparam logic [AW-1:0] HOP_P   = AW'(HOP);
  localparam logic [IW-1:0] LAST_I  = IW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_base_ptr;
  logic [AW:0]     r_occ;
  logic [IW-1:0]   r_idx;
  logic [15:0]     r_frame_cnt;

  logic        w_wr;
  logic        w_rd;
  logic        w_start;
  logic        w_retire;
  logic        w_last;
  logic [AW:0] w_occ_nxt;

  assign in_ready  = (r_occ < DEPTH_W);
  assign w_wr      = in_valid && in_ready;
  assign w_last    = (r_state == STREAM) && (r_idx == LAST_I);
  assign w_rd      = (r_state == STREAM) && out_ready;
  assign w_retire  = w_rd && w_last;
  assign w_start   = (r_state == IDLE) && (r_occ >= FL_W);

  // occ counts from base_ptr, so a retire frees exactly HOP slots
  assign w_occ_nxt = r_occ
                   + (AW+1)'(w_wr)
                   - (w_retire ? HOP_W : '0);

  assign out_valid = (r_state == STREAM);
  assign out_last  = w_last;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_idx   = r_idx;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_retire) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_occ <= w_occ_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_idx    <= '0;
    end else if (w_start) begin
      r_rd_ptr <= r_base_ptr;
      r_idx    <= '0;
    end else if (w_rd) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_idx    <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_ptr  <= '0;
      r_frame_cnt <= '0;
    end else if (w_retire) begin
      r_base_ptr  <= r_base_ptr + HOP_P;
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

`ifdef FRAME_RING_OVF_EN
  logic r_ovf;

  assign ovf = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid && !in_ready) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_frame_ring_buffer.sv
// Directed bench for frame_ring_buffer (FRAME_LEN=8, HOP=4, DEPTH=16).
// Frame k sample i is expected to be input sample 4k+i.
module tb_frame_ring_buffer;

  localparam int BITS = 12;
  localparam int FL   = 8;
  localparam int HOP  = 4;
  localparam int DEP  = 16;
  localparam logic [15:0] NONE = 16'hFFFF;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [BITS-1:0] out_data;
  logic [2:0]      out_idx;
  logic            out_last;
  logic            out_ready;
  logic [15:0]     frame_cnt;
`ifdef FRAME_RING_OVF_EN
  logic            ovf;
  logic            ovf_clr;
`endif

  int n_checks;
  int n_errors;
  int next_sample;
  int data_base;
  int exp_frame;
  int exp_idx;
  int hs_cnt;
  bit prev_last;

  frame_ring_buffer #(
    .BITS(BITS), .FRAME_LEN(FL), .HOP(HOP), .DEPTH(DEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_ready(out_ready),
    .frame_cnt(frame_cnt)
`ifdef FRAME_RING_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int base);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef FRAME_RING_OVF_EN
    ovf_clr   = 1'b0;
`endif
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    next_sample = 0;
    data_base   = base;
    exp_frame   = 0;
    exp_idx     = 0;
    hs_cnt      = 0;
    prev_last   = 1'b0;
  endtask

  // rdy/vld mode: 0 low, 1 high, 2 random
  task automatic run(input int rdy, input int vld, input int lim,
                     input logic [15:0] stop, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      chk("frame_cnt", frame_cnt, exp_frame);
      if (frame_cnt >= stop) break;
      out_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
      in_valid  = (next_sample < lim)
               && ((vld == 2) ? 1'($urandom_range(0, 1)) : (vld == 1));
      in_data   = BITS'(data_base + next_sample);
      if (prev_last) chk("gap", out_valid, 0);
      prev_last = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        chk("data", out_data, BITS'(data_base + HOP*exp_frame + exp_idx));
        chk("idx", out_idx, exp_idx);
        chk("last", out_last, exp_idx == FL-1);
        hs_cnt++;
        exp_idx++;
        if (exp_idx == FL) begin
          exp_idx = 0;
          exp_frame++;
        end
      end
      if (in_valid && in_ready) next_sample++;
      tick();
    end
    if (stop != NONE) chk("budget", frame_cnt >= stop, 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // three overlapping frames from 16 samples
    do_reset(0);
    run(1, 1, 16, 16'd3, 200);
    chk("t1_frames", frame_cnt, 3);
    chk("t1_hs", hs_cnt, 24);
    chk("t1_samples", next_sample, 16);
    run(1, 1, 16, NONE, 6);
    chk("t1_idle", out_valid, 0);

    // back-pressure fills the ring; one frame frees HOP slots
    do_reset(0);
    run(0, 1, 100, NONE, 20);
    chk("t2_full_cnt", next_sample, 16);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_hold_valid", out_valid, 1);
    chk("t2_hold_idx", out_idx, 0);
    chk("t2_hold_data", out_data, 0);
    run(1, 1, 100, 16'd1, 40);
    run(0, 1, 100, NONE, 12);
    chk("t2_refill", next_sample, 20);
    chk("t2_in_ready2", in_ready, 0);
    chk("t2_frames", frame_cnt, 1);

    // random flow control across several pointer wraps
    do_reset(0);
    run(2, 2, 40, 16'd9, 800);
    chk("t3_frames", frame_cnt, 9);
    chk("t3_samples", next_sample, 40);
    chk("t3_hs", hs_cnt, 72);

    // reset mid-frame discards the old samples
    do_reset(0);
    run(0, 1, 8, NONE, 14);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_idx3", out_idx, 3);
    chk("t4_data3", out_data, 3);
    do_reset(100);
    run(1, 1, 7, NONE, 12);
    chk("t4_wait_valid", out_valid, 0);
    chk("t4_wait_hs", hs_cnt, 0);
    run(1, 1, 12, 16'd1, 40);
    chk("t4_frames", frame_cnt, 1);
    chk("t4_hs", hs_cnt, 8);

`ifdef FRAME_RING_OVF_EN
    do_reset(0);
    chk("t5_ovf_rst", ovf, 0);
    run(0, 1, 16, NONE, 22);
    chk("t5_full", in_ready, 0);
    chk("t5_ovf_none", ovf, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t5_ovf_set", ovf, 1);
    tick();
    tick();
    chk("t5_ovf_hold", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t5_ovf_clr", ovf, 0);
    in_valid = 1'b1;
    ovf_clr  = 1'b1;
    tick();
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    chk("t5_ovf_prio", ovf, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_ring_buffer.md
FRAME_RING_BUFFER -- requirements
Module: frame_ring_buffer

Interface
- REQ-001: Reset rst_n, asynchronous, active-low; clock clk.
- REQ-002: Parameter BITS, default 12: sample width.
- REQ-003: Parameter FRAME_LEN, default 256: samples per frame, at least 2.
- REQ-004: Parameter HOP, default 128: frame advance in samples, 1..FRAME_LEN.
- REQ-005: Parameter DEPTH, default 512: ring capacity, power of 2, at least FRAME_LEN+HOP; AW = clog2(DEPTH).
- REQ-006: clk  input  1  clock.
- REQ-007: rst_n  input  1  asynchronous active-low reset.
- REQ-008: in_valid  input  1  sample offered.
- REQ-009: in_data  input  BITS  sample value.
- REQ-010: in_ready  output  1  ring can accept a sample.
- REQ-011: out_valid  output  1  frame sample presented.
- REQ-012: out_data  output  BITS  frame sample.
- REQ-013: out_idx  output  clog2(FRAME_LEN)  index of the sample within its frame.
- REQ-014: out_last  output  1  high when out_idx == FRAME_LEN-1.
- REQ-015: out_ready  input  1  consumer accepts the sample.
- REQ-016: frame_cnt  output  16  completed frames, wraps mod 2^16.

Function
- REQ-017: Write handshake is in_valid && in_ready. On each write, in_data is stored at wr_ptr and wr_ptr increments mod DEPTH.
- REQ-018: occ (AW+1 bits) is the count of samples from base_ptr up to wr_ptr. in_ready = (occ < DEPTH).
- REQ-019: State machine states: IDLE and STREAM.
  - IDLE -> STREAM when occ >= FRAME_LEN; rd_ptr is loaded from base_ptr and idx is cleared.
- REQ-020: In STREAM:
  - out_valid = 1, out_data = mem[rd_ptr], combinational read.
  - On out_valid && out_ready, rd_ptr and idx increment.
  - Without out_ready, all output signals hold their values.
- REQ-021: On the handshake where out_last is high:
  - base_ptr += HOP mod DEPTH, so occ drops by HOP.
  - frame_cnt increments.
  - The machine returns to IDLE, giving a mandatory one-cycle gap between frames.
- REQ-022: A write and a frame retire in the same cycle give occ_next = occ + 1 - HOP.
- REQ-023: Writes are accepted while in STREAM. Samples already in the current frame are never overwritten, which the occ bound guarantees.
- REQ-024: Consecutive frames overlap by FRAME_LEN-HOP samples. Frame k sample i equals input sample k*HOP+i.
- REQ-025: All pointers wrap mod DEPTH with no gap or duplicate at the wrap boundary.
- REQ-026: In IDLE, out_valid = 0 and out_last = 0.

Reset
- REQ-027: On rst_n low, the following clear to 0 immediately:
  - wr_ptr, rd_ptr, base_ptr, occ, idx, frame_cnt
  - out_valid, out_last
  - the state machine returns to IDLE
- REQ-028: During reset, in_ready = 1 once occ = 0.
- REQ-029: Memory contents need not be reset. No stale sample is ever emitted after reset.
- REQ-030: Reset in mid-frame abandons the frame. The first post-reset frame needs FRAME_LEN new samples.

Configuration
- REQ-031: With macro FRAME_RING_OVF_EN defined:
  - Ports ovf (output 1) and ovf_clr (input 1) exist.
  - ovf is sticky and set on in_valid && !in_ready.
  - ovf is cleared by ovf_clr or reset; set takes priority over clear in the same cycle.
- REQ-032: Without FRAME_RING_OVF_EN, the ports and logic are absent and behaviour is otherwise identical.

Verification (BITS=12, FRAME_LEN=8, HOP=4, DEPTH=16)
- REQ-033: Stream samples 0..15, out_ready=1 -> frames {0..7}, {4..11}, {8..15}, each with out_last at idx 7 and a one-cycle gap between them; frame_cnt=3.
- REQ-034: out_ready=0 with input continuous -> in_ready falls after the 16th sample. One frame handshake later, 4 more samples are accepted.
- REQ-035: 40 samples with random out_ready and in_valid -> frame k equals {4k..4k+7} across the pointer wrap, with no loss or duplication.
- REQ-036: rst_n pulsed at out_idx=3 -> out_valid=0 and occ=0 immediately; the next frame starts only after 8 new samples, beginning with the first post-reset sample.
- REQ-037: FRAME_RING_OVF_EN defined, ring full, in_valid=1 for one cycle -> ovf=1, held until ovf_clr; a simultaneous overflow and ovf_clr leaves ovf=1.
